// File: rtl/pmon_eu_agent.sv
// pmon_eu_agent: execution-unit endpoint of the performance monitor.
// Decodes the 24-bit control-unit command stream, maintains N_CNT saturating
// event counters and answers READ commands with one byte-wide AXI-Stream packet
// {EU_ID, arg, counter MSB byte .. LSB byte}.
//
// Handshake semantics (both streams): a transfer happens on a rising clk_i edge
// where tvalid & tready are both high. The command side raises s_cmd_tready only
// in IDLE. The response side drives registered tdata/tvalid/tlast, never looks at
// m_rsp_tready to decide tvalid, and holds tdata/tlast stable until accepted.
module pmon_eu_agent #(
  parameter int              AXIS_DIN_W = 8,
  parameter int              CMD_W      = 24,
  parameter int              ID_W       = 8,
  parameter logic [ID_W-1:0] EU_ID      = 8'd1,
  parameter logic [ID_W-1:0] BCAST_ID   = 8'hFF,
  parameter int              N_CNT      = 4,
  parameter int              CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [N_CNT-1:0]      event_i,
  input  logic [CMD_W-1:0]      s_cmd_tdata,
  input  logic                  s_cmd_tvalid,
  output logic                  s_cmd_tready,
  output logic [AXIS_DIN_W-1:0] m_rsp_tdata,
  output logic                  m_rsp_tvalid,
  input  logic                  m_rsp_tready,
  output logic                  m_rsp_tlast,
  output logic                  dbg_state_o
);

  // Command field layout: {dest_id, opcode, arg}
  localparam int OP_W  = 8;
  localparam int ARG_W = CMD_W - ID_W - OP_W;

  // Packet geometry: header (EU_ID, arg) followed by the counter bytes
  localparam int NDB   = CNT_W / AXIS_DIN_W;
  localparam int NB    = 2 + NDB;
  localparam int IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  localparam logic [OP_W-1:0] OP_START = 8'h01;
  localparam logic [OP_W-1:0] OP_STOP  = 8'h02;
  localparam logic [OP_W-1:0] OP_CLEAR = 8'h03;
  localparam logic [OP_W-1:0] OP_READ  = 8'h04;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    en_q, en_d;
  logic [CNT_W-1:0]        cnt_q [N_CNT];
  logic [CNT_W-1:0]        cnt_d [N_CNT];
  logic [CNT_W-1:0]        snap_q, snap_d;
  logic [ARG_W-1:0]        arg_q, arg_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [AXIS_DIN_W-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;

  logic [ID_W-1:0]         cmd_dest;
  logic [OP_W-1:0]         cmd_op;
  logic [ARG_W-1:0]        cmd_arg;
  logic                    cmd_fire;
  logic                    addr_hit;
  logic                    is_bcast;
  logic                    do_start;
  logic                    do_stop;
  logic                    do_clear;
  logic                    do_read;
  logic                    rsp_fire;
  logic [CNT_W-1:0]        sel_cnt;

  assign cmd_dest = s_cmd_tdata[CMD_W-1 -: ID_W];
  assign cmd_op   = s_cmd_tdata[CMD_W-ID_W-1 -: OP_W];
  assign cmd_arg  = s_cmd_tdata[ARG_W-1:0];

  // Commands are only taken while idle; reset forces tready low immediately.
  assign s_cmd_tready = (state_q == IDLE) && !reset_i;
  assign cmd_fire     = s_cmd_tvalid && s_cmd_tready;

  // Every dest_id is accepted, but only our own ID or broadcast has an effect.
  assign is_bcast = (cmd_dest == BCAST_ID);
  assign addr_hit = (cmd_dest == EU_ID) || is_bcast;
  assign do_start = cmd_fire && addr_hit && (cmd_op == OP_START);
  assign do_stop  = cmd_fire && addr_hit && (cmd_op == OP_STOP);
  assign do_clear = cmd_fire && addr_hit && (cmd_op == OP_CLEAR);
  // Broadcast READs are dropped so that several EUs never answer at once.
  assign do_read  = cmd_fire && addr_hit && !is_bcast && (cmd_op == OP_READ);

  assign rsp_fire = tvalid_q && m_rsp_tready;

  // Snapshot source: selected counter, or all ones for an index past N_CNT-1.
  always_comb begin
    sel_cnt = {CNT_W{1'b1}};
    for (int k = 0; k < N_CNT; k++) begin
      if (cmd_arg == ARG_W'(k)) begin
        sel_cnt = cnt_q[k];
      end
    end
  end

  // Counter and enable update: CLEAR beats a same-cycle event, counting uses the
  // enable value that was current before this cycle's command, counters saturate.
  always_comb begin
    for (int k = 0; k < N_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (do_clear) begin
        cnt_d[k] = '0;
      end else if (en_q && event_i[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    en_d = en_q;
    if (do_start) begin
      en_d = 1'b1;
    end else if (do_stop) begin
      en_d = 1'b0;
    end
  end

  // Response FSM: next state plus the registered stream outputs for next cycle.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    arg_d    = arg_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      IDLE: begin
        if (do_read) begin
          state_d  = SEND;
          snap_d   = sel_cnt;
          arg_d    = cmd_arg;
          idx_d    = '0;
          tdata_d  = AXIS_DIN_W'(EU_ID);
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      SEND: begin
        if (rsp_fire) begin
          if (tlast_q) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tlast_d = (idx_d == LAST_IDX);
            if (idx_q == '0) begin
              tdata_d = AXIS_DIN_W'(arg_q);
            end else begin
              // Counter bytes leave MSB first; the shift exposes the next one.
              tdata_d = snap_q[CNT_W-1 -: AXIS_DIN_W];
              snap_d  = snap_q << AXIS_DIN_W;
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      snap_q   <= '0;
      arg_q    <= '0;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      for (int k = 0; k < N_CNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      snap_q   <= snap_d;
      arg_q    <= arg_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      for (int k = 0; k < N_CNT; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign m_rsp_tdata  = tdata_q;
  assign m_rsp_tvalid = tvalid_q;
  assign m_rsp_tlast  = tlast_q;
  assign dbg_state_o  = state_q;

endmodule
